// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache of 64-bit words serving
// the Mem-stage request port; refills whole lines beat by beat from backing memory.
module dcache_responder #(
  parameter int unsigned NUM_SETS   = 64,
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dc_req,
  input  logic [57:0] dc_line_addr,
  input  logic [2:0]  dc_word_select,
  input  logic [2:0]  dc_byte_offset,
  input  logic [63:0] dc_data_to_cache,
  input  logic        dc_read_write_n,
  input  logic [1:0]  store_type,
  output logic        dc_ack,
  output logic [63:0] dc_data_from_cache,
  output logic        mem_req,
  output logic        mem_we,
  output logic [57:0] mem_addr,
  output logic [2:0]  mem_word,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_byte_en,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata
);

  localparam int unsigned TAG_BITS = 58 - INDEX_BITS;

  typedef enum logic [2:0] {StIdle, StLookup, StRefill, StWrite, StResp} state_e;

  state_e              r_state;
  logic [NUM_SETS-1:0] r_valid;
  logic [TAG_BITS-1:0] r_tag [NUM_SETS];
  logic [63:0]         r_mem [NUM_SETS*8];

  logic [57:0] r_line;
  logic [2:0]  r_word;
  logic [2:0]  r_off;
  logic [63:0] r_sdata;
  logic        r_load;
  logic [1:0]  r_stype;
  logic [2:0]  r_beat;

  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_BITS-1:0]   w_tag;
  logic                  w_hit;
  logic [63:0]           w_cur;
  logic [63:0]           w_wdata;
  logic [7:0]            w_be;
  logic [63:0]           w_merged;

  assign w_idx = r_line[INDEX_BITS-1:0];
  assign w_tag = r_line[57:INDEX_BITS];
  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_cur = r_mem[{w_idx, r_word}];

  // Big-endian lanes: lane k lives in byte 7-k, so shifts use the inverted offset.
  always_comb begin
    w_wdata = 64'd0;
    w_be    = 8'd0;
    unique case (r_stype)
      2'b00: begin
        w_wdata = {56'd0, r_sdata[7:0]} << {~r_off, 3'b000};
        w_be    = 8'h01 << ~r_off;
      end
      2'b01: begin
        w_wdata = {48'd0, r_sdata[15:0]} << {~r_off[2:1], 4'b0000};
        w_be    = 8'h03 << {~r_off[2:1], 1'b0};
      end
      2'b10: begin
        w_wdata = {32'd0, r_sdata[31:0]} << {~r_off[2], 5'b00000};
        w_be    = 8'h0F << {~r_off[2], 2'b00};
      end
      default: begin
        w_wdata = r_sdata;
        w_be    = 8'hFF;
      end
    endcase
    w_merged = w_cur;
    for (int j = 0; j < 8; j++) begin
      if (w_be[j]) w_merged[8*j +: 8] = w_wdata[8*j +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state            <= StIdle;
      r_valid            <= '0;
      r_beat             <= 3'd0;
      dc_ack             <= 1'b0;
      dc_data_from_cache <= 64'd0;
      mem_req            <= 1'b0;
      mem_we             <= 1'b0;
      mem_addr           <= 58'd0;
      mem_word           <= 3'd0;
      mem_wdata          <= 64'd0;
      mem_byte_en        <= 8'd0;
    end else begin
      dc_ack <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (dc_req) begin
            r_line  <= dc_line_addr;
            r_word  <= dc_word_select;
            r_off   <= dc_byte_offset;
            r_sdata <= dc_data_to_cache;
            r_load  <= dc_read_write_n;
            r_stype <= store_type;
            r_state <= StLookup;
          end
        end
        StLookup: begin
          if (r_load) begin
            if (w_hit) begin
              dc_data_from_cache <= w_cur;
              dc_ack             <= 1'b1;
              r_state            <= StResp;
            end else begin
              r_beat   <= 3'd0;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= r_line;
              mem_word <= 3'd0;
              r_state  <= StRefill;
            end
          end else begin
            // Write-through; a miss does not allocate.
            if (w_hit) r_mem[{w_idx, r_word}] <= w_merged;
            mem_req     <= 1'b1;
            mem_we      <= 1'b1;
            mem_addr    <= r_line;
            mem_word    <= r_word;
            mem_wdata   <= w_wdata;
            mem_byte_en <= w_be;
            r_state     <= StWrite;
          end
        end
        StRefill: begin
          if (mem_ack && mem_req) begin
            r_mem[{w_idx, r_beat}] <= mem_rdata;
            if (r_beat == 3'd7) begin
              r_tag[w_idx]   <= w_tag;
              r_valid[w_idx] <= 1'b1;
              mem_req        <= 1'b0;
              r_state        <= StLookup;
            end else begin
              r_beat   <= r_beat + 3'd1;
              mem_word <= r_beat + 3'd1;
            end
          end
        end
        StWrite: begin
          if (mem_ack && mem_req) begin
            mem_req <= 1'b0;
            dc_ack  <= 1'b1;
            r_state <= StResp;
          end
        end
        StResp: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: a pattern-ROM memory model logs every memory beat,
// and expected beats and load data are queued before each request and checked after it.
module tb_dcache_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        dc_req;
  logic [57:0] dc_line_addr;
  logic [2:0]  dc_word_select;
  logic [2:0]  dc_byte_offset;
  logic [63:0] dc_data_to_cache;
  logic        dc_read_write_n;
  logic [1:0]  store_type;
  logic        dc_ack;
  logic [63:0] dc_data_from_cache;
  logic        mem_req;
  logic        mem_we;
  logic [57:0] mem_addr;
  logic [2:0]  mem_word;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_byte_en;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata = 64'd0;

  dcache_responder dut (
    .clk                (clk),
    .reset              (reset),
    .dc_req             (dc_req),
    .dc_line_addr       (dc_line_addr),
    .dc_word_select     (dc_word_select),
    .dc_byte_offset     (dc_byte_offset),
    .dc_data_to_cache   (dc_data_to_cache),
    .dc_read_write_n    (dc_read_write_n),
    .store_type         (store_type),
    .dc_ack             (dc_ack),
    .dc_data_from_cache (dc_data_from_cache),
    .mem_req            (mem_req),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_word           (mem_word),
    .mem_wdata          (mem_wdata),
    .mem_byte_en        (mem_byte_en),
    .mem_ack            (mem_ack),
    .mem_rdata          (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [57:0] addr;
    logic [2:0]  word;
    logic [63:0] wdata;
    logic [7:0]  be;
  } mem_txn_t;

  mem_txn_t    obs_log [256];
  int          obs_cnt = 0;
  int          ack_cnt = 0;
  mem_txn_t    exp_mem [$];
  logic [63:0] exp_resp [$];
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [63:0] pat(input logic [2:0] b);
    return 64'h1111_1111_1111_1111 * (64'(b) + 64'd1);
  endfunction

  // Memory: acks every cycle mem_req is seen, returns a fixed per-beat pattern.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req && !reset) begin
      if (obs_cnt < 256) begin
        obs_log[obs_cnt] = '{we: mem_we, addr: mem_addr, word: mem_word,
                             wdata: mem_wdata, be: mem_byte_en};
      end
      obs_cnt++;
      mem_rdata = mem_we ? 64'd0 : pat(mem_word);
      mem_ack   = 1'b1;
    end
  end

  always @(negedge clk) if (dc_ack === 1'b1) ack_cnt++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_refill(input logic [57:0] line);
    for (int b = 0; b < 8; b++) begin
      exp_mem.push_back('{we: 1'b0, addr: line, word: 3'(b), wdata: 64'd0, be: 8'd0});
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " dc_ack"}, 64'(dc_ack), 64'd0);
    chk({tag, " dc_data"}, dc_data_from_cache, 64'd0);
    chk({tag, " mem_req"}, 64'(mem_req), 64'd0);
    chk({tag, " mem_we"}, 64'(mem_we), 64'd0);
    chk({tag, " mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, " mem_word"}, 64'(mem_word), 64'd0);
    chk({tag, " mem_wdata"}, mem_wdata, 64'd0);
    chk({tag, " mem_be"}, 64'(mem_byte_en), 64'd0);
  endtask

  task automatic do_req(input logic rw, input logic [57:0] line, input logic [2:0] word,
                        input logic [2:0] off, input logic [1:0] st, input logic [63:0] d,
                        input string tag, output int lat);
    int          base;
    int          n;
    logic [63:0] data_before;
    mem_txn_t    e;
    mem_txn_t    o;
    @(posedge clk); #1;
    base             = obs_cnt;
    data_before      = dc_data_from_cache;
    dc_req           = 1'b1;
    dc_read_write_n  = rw;
    dc_line_addr     = line;
    dc_word_select   = word;
    dc_byte_offset   = off;
    store_type       = st;
    dc_data_to_cache = d;
    lat = 0;
    while (dc_ack !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    dc_req = 1'b0;
    chk({tag, " ack"}, 64'(dc_ack), 64'd1);
    if (rw) begin
      if (exp_resp.size() > 0) chk({tag, " load data"}, dc_data_from_cache, exp_resp.pop_front());
    end else begin
      chk({tag, " data held"}, dc_data_from_cache, data_before);
    end
    n = obs_cnt - base;
    chk({tag, " mem beats"}, 64'(n), 64'(exp_mem.size()));
    for (int i = 0; i < n && exp_mem.size() > 0; i++) begin
      e = exp_mem.pop_front();
      o = obs_log[base + i];
      chk($sformatf("%s beat%0d we", tag, i), 64'(o.we), 64'(e.we));
      chk($sformatf("%s beat%0d addr", tag, i), 64'(o.addr), 64'(e.addr));
      chk($sformatf("%s beat%0d word", tag, i), 64'(o.word), 64'(e.word));
      if (e.we) begin
        chk($sformatf("%s beat%0d wdata", tag, i), o.wdata, e.wdata);
        chk($sformatf("%s beat%0d be", tag, i), 64'(o.be), 64'(e.be));
      end
    end
    exp_mem.delete();
    @(posedge clk); #1;
    chk({tag, " ack one cycle"}, 64'(dc_ack), 64'd0);
  endtask

  initial begin
    int lat;
    int base;
    int acks;
    int cyc;
    reset = 1'b1; dc_req = 1'b0; dc_line_addr = '0; dc_word_select = '0;
    dc_byte_offset = '0; dc_data_to_cache = '0; dc_read_write_n = 1'b1; store_type = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    reset = 1'b0;

    push_refill(58'h40);
    exp_resp.push_back(64'h3333_3333_3333_3333);
    do_req(1'b1, 58'h40, 3'd2, 3'd0, 2'd0, 64'd0, "ld_miss", lat);

    exp_resp.push_back(64'h3333_3333_3333_3333);
    do_req(1'b1, 58'h40, 3'd2, 3'd0, 2'd0, 64'd0, "ld_hit", lat);
    chk("ld_hit latency", 64'(lat), 64'd2);

    exp_mem.push_back('{we: 1'b1, addr: 58'h40, word: 3'd2,
                        wdata: 64'h0000_0000_00AB_0000, be: 8'h04});
    do_req(1'b0, 58'h40, 3'd2, 3'd5, 2'b00, 64'hFFFF_FFFF_FFFF_FFAB, "stb", lat);
    chk("stb latency", 64'(lat), 64'd3);

    exp_resp.push_back(64'h3333_3333_33AB_3333);
    do_req(1'b1, 58'h40, 3'd2, 3'd0, 2'd0, 64'd0, "ld_after_stb", lat);

    exp_mem.push_back('{we: 1'b1, addr: 58'h80, word: 3'd1,
                        wdata: 64'h0000_BEEF_0000_0000, be: 8'h30});
    do_req(1'b0, 58'h80, 3'd1, 3'd2, 2'b01, 64'h1234_5678_9ABC_BEEF, "sth_miss", lat);

    exp_resp.push_back(64'h3333_3333_33AB_3333);
    do_req(1'b1, 58'h40, 3'd2, 3'd0, 2'd0, 64'd0, "ld_set0_kept", lat);
    chk("ld_set0_kept latency", 64'(lat), 64'd2);

    push_refill(58'h80);
    exp_resp.push_back(64'h2222_2222_2222_2222);
    do_req(1'b1, 58'h80, 3'd1, 3'd0, 2'd0, 64'd0, "ld_80_miss", lat);

    exp_mem.push_back('{we: 1'b1, addr: 58'h80, word: 3'd1,
                        wdata: 64'h0123_4567_89AB_CDEF, be: 8'hFF});
    do_req(1'b0, 58'h80, 3'd1, 3'd0, 2'b11, 64'h0123_4567_89AB_CDEF, "std", lat);

    exp_resp.push_back(64'h0123_4567_89AB_CDEF);
    do_req(1'b1, 58'h80, 3'd1, 3'd0, 2'd0, 64'd0, "ld_after_std", lat);
    chk("ld_after_std latency", 64'(lat), 64'd2);

    exp_mem.push_back('{we: 1'b1, addr: 58'h80, word: 3'd3,
                        wdata: 64'h0000_0000_DEAD_BEEF, be: 8'h0F});
    do_req(1'b0, 58'h80, 3'd3, 3'd4, 2'b10, 64'hFFFF_0000_DEAD_BEEF, "st_word", lat);

    exp_resp.push_back(64'h4444_4444_DEAD_BEEF);
    do_req(1'b1, 58'h80, 3'd3, 3'd0, 2'd0, 64'd0, "ld_after_st", lat);

    // Abort a refill with reset once beat 3 has been presented.
    @(posedge clk); #1;
    base = obs_cnt;
    acks = ack_cnt;
    dc_req = 1'b1; dc_read_write_n = 1'b1; dc_line_addr = 58'h40; dc_word_select = 3'd5;
    cyc = 0;
    while (obs_cnt - base < 4 && cyc < 100) begin
      @(negedge clk); #2;
      cyc++;
    end
    chk("abort beats before reset", 64'(obs_cnt - base), 64'd4);
    reset = 1'b1;
    dc_req = 1'b0;
    @(posedge clk); #1;
    chk_outputs_zero("abort reset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort no ack", 64'(ack_cnt - acks), 64'd0);
    chk("abort no more beats", 64'(obs_cnt - base), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("abort beat%0d word", i), 64'(obs_log[base + i].word), 64'(i));
    end

    push_refill(58'h40);
    exp_resp.push_back(64'h6666_6666_6666_6666);
    do_req(1'b1, 58'h40, 3'd5, 3'd0, 2'd0, 64'd0, "ld_after_abort", lat);

    exp_resp.push_back(64'h6666_6666_6666_6666);
    do_req(1'b1, 58'h40, 3'd5, 3'd0, 2'd0, 64'd0, "ld_after_abort_hit", lat);
    chk("ld_after_abort_hit latency", 64'(lat), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
